// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell plus a carry flop, LSB first.
// Optional SERIAL_ADDER_ACC_EN adds an acc input that feeds the sum back as A.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef SERIAL_ADDER_ACC_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q, ovf_q;

  logic             accept;
  logic             last;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] a_src;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_ACC_EN
  assign a_src = acc ? sum_q : a;
`else
  assign a_src = a;
`endif

  // The single full-adder cell
  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_bit = (a_q[0] & b_q[0]) |
                 (a_q[0] & carry_q) |
                 (b_q[0] & carry_q);

  always_comb begin
    res_sh           = res_q >> 1;
    res_sh[WIDTH-1]  = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = DONE;
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a_src;
      b_q     <= sub ? ~b : b;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= sub ? 1'b1 : cin;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= res_sh;
      cnt_q   <= cnt_q + CW'(1);
      carry_q <= c_bit;
    end
  end

  // Results only move on the final RUN edge; held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == RUN && last) begin
      sum_q  <= res_sh;
      cout_q <= c_bit;
      ovf_q  <= carry_q ^ c_bit;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=1 and WIDTH=8.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       start1 = 0, a1 = 0, b1 = 0, cin1 = 0, sub1 = 0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  logic       start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_ACC_EN
  logic       acc8 = 0;
  logic       acc1 = 0;
`endif

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
`ifdef SERIAL_ADDER_ACC_EN
    .acc(acc1),
`endif
    .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
`ifdef SERIAL_ADDER_ACC_EN
    .acc(acc8),
`endif
    .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .overflow(ovf8)
  );

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic s);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; cin8 = ~c; sub8 = ~s;
  endtask

  task automatic wait8(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy8) bcnt++;
      if (done8) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      fails++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    tests++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'h0) begin
      fails++;
      $display("FAIL reset1: got %b want 00000",
               {busy1, done1, sum1, cout1, ovf1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_adder;
    logic [1:0] exp_tab [8];
    exp_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    for (int v = 0; v < 8; v++) begin
      int         dcnt;
      logic [1:0] got;
      logic       gov;
      logic [2:0] vv;
      vv = 3'(v);
      dcnt = 0; got = 2'bxx; gov = 1'bx;
      a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; sub1 = 1'b0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~a1; b1 = ~b1;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (done1) begin
          dcnt++;
          got = {cout1, sum1};
          gov = ovf1;
          if (i != 2) dcnt += 10;
        end
      end
      tests++;
      if (got !== exp_tab[v]) begin
        fails++;
        $display("FAIL fa%0d: got {cout,sum}=%0d want %0d", v, got, exp_tab[v]);
      end
      tests++;
      if (dcnt != 1) begin
        fails++;
        $display("FAIL fa%0d_done: got done count code %0d want 1", v, dcnt);
      end
      tests++;
      if (gov !== (vv[0] ^ exp_tab[v][1])) begin
        fails++;
        $display("FAIL fa%0d_ovf: got %b want %b", v, gov, vv[0] ^ exp_tab[v][1]);
      end
    end
  endtask

  task automatic test_add_sub8;
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic       vs [6];
    logic [7:0] es [6];
    logic       ec [6];
    logic       eo [6];
    va = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h12};
    vb = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01, 8'h34};
    vs = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    es = '{8'h10, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'h46};
    ec = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    eo = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int v = 0; v < 6; v++) begin
      int lat, bc;
      start_op8(va[v], vb[v], 1'b0, vs[v]);
      wait8(lat, bc);
      tests++;
      if (lat != 9 || bc != 8) begin
        fails++;
        $display("FAIL op%0d_timing: got done@%0d busy=%0d want 9/8", v, lat, bc);
      end
      tests++;
      if ({sum8, cout8, ovf8} !== {es[v], ec[v], eo[v]}) begin
        fails++;
        $display("FAIL op%0d: got sum=%h cout=%b ovf=%b want %h %b %b",
                 v, sum8, cout8, ovf8, es[v], ec[v], eo[v]);
      end
    end
  endtask

  task automatic test_cin8;
    int lat, bc;
    start_op8(8'h20, 8'h03, 1'b1, 1'b0);
    wait8(lat, bc);
    tests++;
    if (lat != 9 || {sum8, cout8} !== 9'h048) begin
      fails++;
      $display("FAIL cin8: got lat=%0d sum=%h cout=%b want 9 24 0",
               lat, sum8, cout8);
    end
  endtask

  task automatic test_run_ignore;
    int lat, bc;
    start_op8(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(lat, bc);
    tests++;
    if (lat != 6 || bc != 5) begin
      fails++;
      $display("FAIL ignore_timing: got done@%0d busy=%0d want 6/5", lat, bc);
    end
    tests++;
    if (sum8 !== 8'h46) begin
      fails++;
      $display("FAIL ignore_sum: got %h want 46", sum8);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    start_op8(8'h01, 8'h02, 1'b0, 1'b0);
    wait8(lat, bc);
    tests++;
    if (lat != 9 || sum8 !== 8'h03) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d sum=%h want 9 03", lat, sum8);
    end
    a8 = 8'h0A; b8 = 8'h05; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    tests++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h03) begin
      fails++;
      $display("FAIL b2b_gap: got busy=%b done=%b sum=%h want 1 0 03",
               busy8, done8, sum8);
    end
    wait8(lat, bc);
    tests++;
    if (lat != 8 || sum8 !== 8'h0F) begin
      fails++;
      $display("FAIL b2b_second: got lat=%0d sum=%h want 8 0f", lat, sum8);
    end
    @(negedge clk);
    tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h0F) begin
      fails++;
      $display("FAIL b2b_idle: got done=%b busy=%b sum=%h want 0 0 0f",
               done8, busy8, sum8);
    end
  endtask

  task automatic test_reset_mid;
    int dcnt;
    dcnt = 0;
    start_op8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      fails++;
      $display("FAIL rst_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b want 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    tests++;
    if (dcnt != 0 || sum8 !== 8'h00) begin
      fails++;
      $display("FAIL rst_nodone: got activity=%0d sum=%h want 0 00", dcnt, sum8);
    end
  endtask

`ifdef SERIAL_ADDER_ACC_EN
  task automatic test_acc;
    int lat, bc;
    acc8 = 1'b0;
    start_op8(8'h10, 8'h00, 1'b0, 1'b0);
    wait8(lat, bc);
    tests++;
    if (sum8 !== 8'h10) begin
      fails++;
      $display("FAIL acc_seed: got %h want 10", sum8);
    end
    acc8 = 1'b1;
    start_op8(8'hEE, 8'h05, 1'b0, 1'b0);
    acc8 = 1'b0;
    wait8(lat, bc);
    tests++;
    if (lat != 9 || sum8 !== 8'h15) begin
      fails++;
      $display("FAIL acc_sum: got lat=%0d sum=%h want 9 15", lat, sum8);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_full_adder;
    test_add_sub8;
    test_cin8;
    test_run_ignore;
    test_back_to_back;
    test_reset_mid;
`ifdef SERIAL_ADDER_ACC_EN
    test_acc;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
